// File: rtl/axi2apb_pkg.sv
// Shared APB / AXI-lite bus definitions: 32-bit address and data, 4-bit byte strobes.
// No logic, no latency.
// No backpressure of its own; the valid/ready fields carry the channel flow control.
package axi2apb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0] paddr;
        logic [2:0]        pprot;
        logic              penable;
        logic              pwrite;
        logic [DATA_W-1:0] pwdata;
        logic [STRB_W-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic              pready;
        logic [DATA_W-1:0] prdata;
        logic              pslverr;
    } apb_resp_t;

    typedef struct packed {
        logic              aw_valid;
        logic [ADDR_W-1:0] aw_addr;
        logic [2:0]        aw_prot;
        logic              w_valid;
        logic [DATA_W-1:0] w_data;
        logic [STRB_W-1:0] w_strb;
        logic              b_ready;
        logic              ar_valid;
        logic [ADDR_W-1:0] ar_addr;
        logic [2:0]        ar_prot;
        logic              r_ready;
    } axi_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic              b_valid;
        logic [1:0]        b_resp;
        logic              ar_ready;
        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic [1:0]        r_resp;
    } axi_resp_t;

    // SLVERR and DECERR both have the MSB set; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/apb_to_axi_lite.sv
// APB completer that replays each transfer as a single AXI-lite read or write.
// Latency: setup at T, AXI valids at T+1, B/R accepted at T+2 earliest, pready at T+3.
// Backpressure: AXI readies/valids stall the FSM; APB is held via pready=0 until done.
//
// Ports: clk_i/rst_i (sync, active-high reset), psel_i + apb_req_i/apb_resp_o on the
// APB side, axi_req_o/axi_resp_i on the AXI-lite manager side.
module apb_to_axi_lite
    import axi2apb::*;
#(
    parameter type apb_req_t  = axi2apb::apb_req_t,
    parameter type apb_resp_t = axi2apb::apb_resp_t,
    parameter type axi_req_t  = axi2apb::axi_req_t,
    parameter type axi_resp_t = axi2apb::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      psel_i,
    input  apb_req_t  apb_req_i,
    output apb_resp_t apb_resp_o,
    output axi_req_t  axi_req_o,
    input  axi_resp_t axi_resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Transfer captured at the setup phase; AXI payloads come only from these,
    // so they stay stable whatever the APB side does mid-transfer.
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        prot_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;

    logic              aw_done_q;
    logic              w_done_q;
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] prdata_q;

    logic setup;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign setup = psel_i && !apb_req_i.penable;

    assign aw_hs = axi_req_o.aw_valid && axi_resp_i.aw_ready;
    assign w_hs  = axi_req_o.w_valid  && axi_resp_i.w_ready;
    assign ar_hs = axi_req_o.ar_valid && axi_resp_i.ar_ready;
    assign b_hs  = axi_req_o.b_ready  && axi_resp_i.b_valid;
    assign r_hs  = axi_req_o.r_ready  && axi_resp_i.r_valid;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (write_q) begin
                    // A handshake in the current cycle counts as completed.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        state_d = RESP;
                    end
                end else if (ar_hs) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (write_q ? b_hs : r_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw_addr  = addr_q;
        axi_req_o.aw_prot  = prot_q;
        axi_req_o.w_data   = wdata_q;
        axi_req_o.w_strb   = strb_q;
        axi_req_o.ar_addr  = addr_q;
        axi_req_o.ar_prot  = prot_q;
        axi_req_o.aw_valid = (state_q == REQ) && write_q && !aw_done_q;
        axi_req_o.w_valid  = (state_q == REQ) && write_q && !w_done_q;
        axi_req_o.ar_valid = (state_q == REQ) && !write_q;
        axi_req_o.b_ready  = (state_q == RESP) && write_q;
        axi_req_o.r_ready  = (state_q == RESP) && !write_q;

        apb_resp_o         = '0;
        apb_resp_o.prdata  = prdata_q;
        apb_resp_o.pready  = (state_q == DONE);
        apb_resp_o.pslverr = (state_q == DONE) && resp_is_err(resp_q);
    end

    // Capture registers, per-channel done flags and response data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            prot_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= RESP_OKAY;
            prdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        addr_q    <= apb_req_i.paddr;
                        prot_q    <= apb_req_i.pprot;
                        write_q   <= apb_req_i.pwrite;
                        wdata_q   <= apb_req_i.pwdata;
                        strb_q    <= apb_req_i.pstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                REQ: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (write_q && b_hs) begin
                        resp_q <= axi_resp_i.b_resp;
                    end
                    if (!write_q && r_hs) begin
                        resp_q   <= axi_resp_i.r_resp;
                        prdata_q <= axi_resp_i.r_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
